instr_queue_dual: RTL and testbench
===================================

# instr_queue_dual

Dual-port instruction queue for the superscalar front end, the parametrised successor of the single-issue instruction FIFO. It sits between fetch and the dual decode/issue slots. Each cycle it accepts 0–2 instructions in program order and retires 0–2 instructions in program order. It exposes the two oldest entries, occupancy, and push/pop capability flags so fetch and issue can throttle themselves without overrunning it.

## Interface
- IWIDTH, 32, instruction width in bits
- DEPTH, 3, log2 of entry count; NENT = 2**DEPTH; DEPTH >= 1 required
- q_clk  in  1  clock; all state updates on falling edge
- q_rst  in  1  reset, asynchronous, active-low
- q_i_flush  in  1  synchronous flush; port present only with IQ_FLUSH_EN
- q_i_wr_num  in  2  instructions to push this cycle (0,1,2; 3 = no push, drop flagged)
- q_i_instr0  in  IWIDTH  older instruction of push group
- q_i_instr1  in  IWIDTH  younger instruction (used only when wr_num=2)
- q_i_rd_num  in  2  instructions to pop this cycle (0,1,2; 3 = no pop, drop flagged)
- q_o_instr0  out  IWIDTH  entry at head
- q_o_instr1  out  IWIDTH  entry at head+1 (mod NENT)
- q_o_valid0 / q_o_valid1  out  1 each  count>=1 / count>=2
- q_o_count  out  DEPTH+1  occupancy, 0..NENT
- q_o_full  out  1  count==NENT
- q_o_empty  out  1  count==0
- q_o_can_push2  out  1  NENT-count >= 2
- q_o_drop  out  1  one-cycle pulse: a push or pop request was rejected in the last update

## Operation
- State: data array NENT×IWIDTH, wr_ptr and rd_ptr (DEPTH bits, natural modulo-NENT wrap), count (DEPTH+1 bits).
- Reset: array zeroed; pointers, count, and drop cleared. Outputs are then instr0/1=0, valid0/1=0, count=0, empty=1, full=0, can_push2=1 (0 if NENT<2), drop=0.
- Pop is all-or-nothing. It is accepted iff rd_num ∈{1,2} and count >= rd_num, using the pre-update count. On accept, rd_ptr += rd_num.
- Push is all-or-nothing. It is accepted iff wr_num ∈{1,2} and NENT-count >= wr_num, using the pre-update count. A same-cycle pop does not grant extra space. On accept, instr0 is written to wr_ptr, instr1 to wr_ptr+1 (mod NENT), and wr_ptr += wr_num.
- count_next = count + pushed - popped; both operations may occur in the same edge.
- Pop from empty is rejected even if a push arrives that cycle; there is no bypass.
- drop_next = 1 if any nonzero request was rejected, or if wr_num==3 or rd_num==3; else 0. State is otherwise unchanged by a rejected operation.
- Outputs are combinational from registered state. instr1 is undefined-but-stable (old array contents) when valid1=0.

## Timing
- Write-to-visible latency: 1 falling edge. An instruction pushed into an empty queue appears on instr0 with valid0=1 after that edge.
- Pop takes effect at the edge. The next entries appear immediately after it.
- Wrap-around: a 2-wide push or pop that straddles index NENT-1→0 is legal and must split correctly.
- Full with rd_num=1 and wr_num=1: the push is rejected (pre-update rule), the pop is accepted, and drop=1.
- Async reset mid-operation: state clears immediately regardless of the clock, and requests in flight are lost.

## Configuration
- IQ_FLUSH_EN defined: q_i_flush exists. When flush=1 at an edge, pointers and count go to 0 and drop to 0, and any push or pop in the same cycle is ignored. The array is not cleared, so outputs become valid=0 and empty=1.
- IQ_FLUSH_EN undefined: the port is absent and there is no flush logic; pipeline redirect requires reset.

## Test plan
- Reset, then push A (wr_num=1), then push B,C (wr_num=2) -> count=3; instr0=A, instr1=B; valid0=valid1=1.
- DEPTH=3: push 2 per cycle ×4 -> full=1, count=8, can_push2=0; a fifth push of 2 -> drop=1, count stays 8.
- Fill 7, pop 2, push 2 across index 7→0 -> pops return entries in program order with no loss or duplication through the wrap.
- Full, rd_num=1 and wr_num=1 in the same cycle -> count=7, drop=1; then empty, rd_num=2 with wr_num=2 -> count=2, drop=1.
- count=1, rd_num=2 -> rejected, count=1, drop=1; wr_num=3 -> drop=1, no state change.
- IQ_FLUSH_EN: count=5, flush with wr_num=2 -> count=0, empty=1; without macro, compile with no q_i_flush port.

Source files
------------

// File: rtl/instr_queue_dual_if.sv
// Fetch/issue-facing bundle for the dual-port instruction queue.
// Optional flush signal exists only when IQ_FLUSH_EN is defined.
interface instr_queue_dual_if #(
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 3
);
    logic              q_i_flush;
    logic [1:0]        q_i_wr_num;
    logic [IWIDTH-1:0] q_i_instr0;
    logic [IWIDTH-1:0] q_i_instr1;
    logic [1:0]        q_i_rd_num;
    logic [IWIDTH-1:0] q_o_instr0;
    logic [IWIDTH-1:0] q_o_instr1;
    logic              q_o_valid0;
    logic              q_o_valid1;
    logic [DEPTH:0]    q_o_count;
    logic              q_o_full;
    logic              q_o_empty;
    logic              q_o_can_push2;
    logic              q_o_drop;

    modport master (
`ifdef IQ_FLUSH_EN
        output q_i_flush,
`endif
        output q_i_wr_num, q_i_instr0, q_i_instr1, q_i_rd_num,
        input  q_o_instr0, q_o_instr1, q_o_valid0, q_o_valid1,
        input  q_o_count, q_o_full, q_o_empty, q_o_can_push2,
        input  q_o_drop
    );

    modport slave (
`ifdef IQ_FLUSH_EN
        input  q_i_flush,
`endif
        input  q_i_wr_num, q_i_instr0, q_i_instr1, q_i_rd_num,
        output q_o_instr0, q_o_instr1, q_o_valid0, q_o_valid1,
        output q_o_count, q_o_full, q_o_empty, q_o_can_push2,
        output q_o_drop
    );
endinterface

// File: rtl/instr_queue_dual.sv
// Dual-port in-order instruction queue between fetch and dual issue.
// Define IQ_FLUSH_EN to add the synchronous q_i_flush redirect input.
module instr_queue_dual #(
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 3
) (
    input logic              q_clk,
    input logic              q_rst,
    instr_queue_dual_if.slave q
);
    localparam int            NENT   = 2 ** DEPTH;
    localparam int            CW     = DEPTH + 1;
    localparam logic [CW-1:0] NENT_C = CW'(NENT);

    logic [IWIDTH-1:0] mem [NENT];
    logic [DEPTH-1:0]  wr_ptr;
    logic [DEPTH-1:0]  rd_ptr;
    logic [CW-1:0]     count;
    logic              drop;

    logic [CW-1:0]     space;
    logic [CW-1:0]     wr_n;
    logic [CW-1:0]     rd_n;
    logic [CW-1:0]     push_n;
    logic [CW-1:0]     pop_n;
    logic [CW-1:0]     count_next;
    logic              push_ok;
    logic              pop_ok;
    logic              drop_next;
    logic              flush;

`ifdef IQ_FLUSH_EN
    assign flush = q.q_i_flush;
`else
    assign flush = 1'b0;
`endif

    // Accept/reject decisions use only the pre-update occupancy.
    always_comb begin
        wr_n    = CW'(q.q_i_wr_num);
        rd_n    = CW'(q.q_i_rd_num);
        space   = NENT_C - count;
        push_ok = (q.q_i_wr_num == 2'd1 || q.q_i_wr_num == 2'd2)
                  && (space >= wr_n);
        pop_ok  = (q.q_i_rd_num == 2'd1 || q.q_i_rd_num == 2'd2)
                  && (count >= rd_n);
        push_n  = push_ok ? wr_n : '0;
        pop_n   = pop_ok ? rd_n : '0;
        count_next = count + push_n - pop_n;
        drop_next  = ((q.q_i_wr_num != 2'd0) && !push_ok)
                     || ((q.q_i_rd_num != 2'd0) && !pop_ok);
    end

    // Queue state advances on the falling edge; reset clears everything.
    always_ff @(negedge q_clk or negedge q_rst) begin
        if (!q_rst) begin
            for (int i = 0; i < NENT; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= q.q_i_instr0;
                if (q.q_i_wr_num == 2'd2) begin
                    mem[wr_ptr + DEPTH'(1)] <= q.q_i_instr1;
                end
                wr_ptr <= wr_ptr + DEPTH'(q.q_i_wr_num);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH'(q.q_i_rd_num);
            end
            count <= count_next;
            drop  <= drop_next;
        end
    end

    // Status and head entries come straight from registered state.
    always_comb begin
        q.q_o_instr0    = mem[rd_ptr];
        q.q_o_instr1    = mem[rd_ptr + DEPTH'(1)];
        q.q_o_valid0    = (count >= CW'(1));
        q.q_o_valid1    = (count >= CW'(2));
        q.q_o_count     = count;
        q.q_o_full      = (count == NENT_C);
        q.q_o_empty     = (count == '0);
        q.q_o_can_push2 = (space >= CW'(2));
        q.q_o_drop      = drop;
    end
endmodule

// File: tb/tb_instr_queue_dual.sv
// Directed bench for instr_queue_dual (DEPTH=3, eight entries).
// Stimulus on rising edge, DUT updates on falling edge, checks 1 after.
module tb_instr_queue_dual;
    logic q_clk = 1'b0;
    logic q_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instr_queue_dual_if #(.IWIDTH(32), .DEPTH(3)) qif ();

    instr_queue_dual #(.IWIDTH(32), .DEPTH(3)) dut (
        .q_clk (q_clk),
        .q_rst (q_rst),
        .q     (qif)
    );

    always #5 q_clk = ~q_clk;

    task automatic idle_inputs();
        qif.q_i_wr_num = 2'd0;
        qif.q_i_rd_num = 2'd0;
        qif.q_i_instr0 = '0;
        qif.q_i_instr1 = '0;
        qif.q_i_flush  = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge q_clk);
        idle_inputs();
        q_rst = 1'b0;
        #2;
        q_rst = 1'b1;
    endtask

    task automatic cycle(input logic [1:0] wr, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] rd);
        @(posedge q_clk);
        qif.q_i_wr_num = wr;
        qif.q_i_instr0 = a;
        qif.q_i_instr1 = b;
        qif.q_i_rd_num = rd;
        @(negedge q_clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        if (qif.q_o_instr0 !== 32'h0) begin errors++; $display("FAIL reset_instr0: got %h want 0", qif.q_o_instr0); end checks++;
        if (qif.q_o_instr1 !== 32'h0) begin errors++; $display("FAIL reset_instr1: got %h want 0", qif.q_o_instr1); end checks++;
        if (qif.q_o_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", qif.q_o_valid0); end checks++;
        if (qif.q_o_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", qif.q_o_valid1); end checks++;
        if (qif.q_o_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", qif.q_o_count); end checks++;
        if (qif.q_o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", qif.q_o_empty); end checks++;
        if (qif.q_o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", qif.q_o_full); end checks++;
        if (qif.q_o_can_push2 !== 1'b1) begin errors++; $display("FAIL reset_can_push2: got %b want 1", qif.q_o_can_push2); end checks++;
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", qif.q_o_drop); end checks++;
    endtask

    task automatic test_push_basic();
        apply_reset();
        cycle(2'd1, 32'hAAAA_0001, 32'h0, 2'd0);
        if (qif.q_o_instr0 !== 32'hAAAA_0001) begin errors++; $display("FAIL push1_instr0: got %h want aaaa0001", qif.q_o_instr0); end checks++;
        if (qif.q_o_valid0 !== 1'b1 || qif.q_o_valid1 !== 1'b0) begin errors++; $display("FAIL push1_valid: got %b%b want 10", qif.q_o_valid0, qif.q_o_valid1); end checks++;
        cycle(2'd2, 32'hBBBB_0002, 32'hCCCC_0003, 2'd0);
        if (qif.q_o_count !== 4'd3) begin errors++; $display("FAIL push_count: got %0d want 3", qif.q_o_count); end checks++;
        if (qif.q_o_instr0 !== 32'hAAAA_0001) begin errors++; $display("FAIL push_instr0: got %h want aaaa0001", qif.q_o_instr0); end checks++;
        if (qif.q_o_instr1 !== 32'hBBBB_0002) begin errors++; $display("FAIL push_instr1: got %h want bbbb0002", qif.q_o_instr1); end checks++;
        if (qif.q_o_valid0 !== 1'b1 || qif.q_o_valid1 !== 1'b1) begin errors++; $display("FAIL push_valid: got %b%b want 11", qif.q_o_valid0, qif.q_o_valid1); end checks++;
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL push_drop: got %b want 0", qif.q_o_drop); end checks++;
    endtask

    task automatic test_fill_full();
        apply_reset();
        for (int k = 0; k < 8; k += 2) begin
            cycle(2'd2, 32'h1000_0000 + k, 32'h1000_0001 + k, 2'd0);
        end
        if (qif.q_o_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", qif.q_o_count); end checks++;
        if (qif.q_o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", qif.q_o_full); end checks++;
        if (qif.q_o_can_push2 !== 1'b0) begin errors++; $display("FAIL full_can_push2: got %b want 0", qif.q_o_can_push2); end checks++;
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL full_drop_pre: got %b want 0", qif.q_o_drop); end checks++;
        cycle(2'd2, 32'hDEAD_0000, 32'hDEAD_0001, 2'd0);
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL overflow_drop: got %b want 1", qif.q_o_drop); end checks++;
        if (qif.q_o_count !== 4'd8) begin errors++; $display("FAIL overflow_count: got %0d want 8", qif.q_o_count); end checks++;
        if (qif.q_o_instr0 !== 32'h1000_0000) begin errors++; $display("FAIL overflow_instr0: got %h want 10000000", qif.q_o_instr0); end checks++;
        cycle(2'd0, 32'h0, 32'h0, 2'd0);
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse: got %b want 0", qif.q_o_drop); end checks++;
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle(2'd2, 32'h2000_0001, 32'h2000_0002, 2'd0);
        cycle(2'd2, 32'h2000_0003, 32'h2000_0004, 2'd0);
        cycle(2'd2, 32'h2000_0005, 32'h2000_0006, 2'd0);
        cycle(2'd1, 32'h2000_0007, 32'h0, 2'd0);
        if (qif.q_o_count !== 4'd7) begin errors++; $display("FAIL wrap_fill7: got %0d want 7", qif.q_o_count); end checks++;
        cycle(2'd0, 32'h0, 32'h0, 2'd2);
        if (qif.q_o_instr0 !== 32'h2000_0003) begin errors++; $display("FAIL wrap_pop2: got %h want 20000003", qif.q_o_instr0); end checks++;
        cycle(2'd2, 32'h2000_0008, 32'h2000_0009, 2'd0);
        if (qif.q_o_count !== 4'd7) begin errors++; $display("FAIL wrap_count: got %0d want 7", qif.q_o_count); end checks++;
        for (int k = 3; k <= 9; k += 2) begin
            if (qif.q_o_instr0 !== 32'h2000_0000 + k) begin errors++; $display("FAIL wrap_order0_%0d: got %h want %h", k, qif.q_o_instr0, 32'h2000_0000 + k); end checks++;
            if (k < 9) begin
                if (qif.q_o_instr1 !== 32'h2000_0001 + k) begin errors++; $display("FAIL wrap_order1_%0d: got %h want %h", k, qif.q_o_instr1, 32'h2000_0001 + k); end checks++;
                cycle(2'd0, 32'h0, 32'h0, 2'd2);
            end else begin
                cycle(2'd0, 32'h0, 32'h0, 2'd1);
            end
        end
        if (qif.q_o_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", qif.q_o_empty); end checks++;
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL wrap_drop: got %b want 0", qif.q_o_drop); end checks++;
    endtask

    task automatic test_full_pushpop();
        apply_reset();
        for (int k = 0; k < 8; k += 2) begin
            cycle(2'd2, 32'h3000_0000 + k, 32'h3000_0001 + k, 2'd0);
        end
        cycle(2'd1, 32'h3000_00FF, 32'h0, 2'd1);
        if (qif.q_o_count !== 4'd7) begin errors++; $display("FAIL fullpp_count: got %0d want 7", qif.q_o_count); end checks++;
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL fullpp_drop: got %b want 1", qif.q_o_drop); end checks++;
        if (qif.q_o_instr0 !== 32'h3000_0001) begin errors++; $display("FAIL fullpp_instr0: got %h want 30000001", qif.q_o_instr0); end checks++;
        apply_reset();
        cycle(2'd2, 32'h4000_0000, 32'h4000_0001, 2'd2);
        if (qif.q_o_count !== 4'd2) begin errors++; $display("FAIL emptypp_count: got %0d want 2", qif.q_o_count); end checks++;
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL emptypp_drop: got %b want 1", qif.q_o_drop); end checks++;
        if (qif.q_o_instr0 !== 32'h4000_0000) begin errors++; $display("FAIL emptypp_instr0: got %h want 40000000", qif.q_o_instr0); end checks++;
        if (qif.q_o_instr1 !== 32'h4000_0001) begin errors++; $display("FAIL emptypp_instr1: got %h want 40000001", qif.q_o_instr1); end checks++;
    endtask

    task automatic test_underflow();
        apply_reset();
        cycle(2'd1, 32'h5000_0000, 32'h0, 2'd0);
        cycle(2'd0, 32'h0, 32'h0, 2'd2);
        if (qif.q_o_count !== 4'd1) begin errors++; $display("FAIL under_count: got %0d want 1", qif.q_o_count); end checks++;
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL under_drop: got %b want 1", qif.q_o_drop); end checks++;
        cycle(2'd3, 32'h5000_0001, 32'h5000_0002, 2'd0);
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL wr3_drop: got %b want 1", qif.q_o_drop); end checks++;
        if (qif.q_o_count !== 4'd1) begin errors++; $display("FAIL wr3_count: got %0d want 1", qif.q_o_count); end checks++;
        if (qif.q_o_instr0 !== 32'h5000_0000) begin errors++; $display("FAIL wr3_instr0: got %h want 50000000", qif.q_o_instr0); end checks++;
        cycle(2'd0, 32'h0, 32'h0, 2'd0);
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL idle_drop: got %b want 0", qif.q_o_drop); end checks++;
        cycle(2'd0, 32'h0, 32'h0, 2'd3);
        if (qif.q_o_drop !== 1'b1) begin errors++; $display("FAIL rd3_drop: got %b want 1", qif.q_o_drop); end checks++;
        if (qif.q_o_count !== 4'd1) begin errors++; $display("FAIL rd3_count: got %0d want 1", qif.q_o_count); end checks++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        cycle(2'd2, 32'h6000_0000, 32'h6000_0001, 2'd0);
        @(posedge q_clk);
        qif.q_i_wr_num = 2'd2;
        qif.q_i_instr0 = 32'h6000_0002;
        qif.q_i_instr1 = 32'h6000_0003;
        #2;
        q_rst = 1'b0;
        #1;
        if (qif.q_o_count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", qif.q_o_count); end checks++;
        if (qif.q_o_instr0 !== 32'h0) begin errors++; $display("FAIL arst_instr0: got %h want 0", qif.q_o_instr0); end checks++;
        if (qif.q_o_valid0 !== 1'b0) begin errors++; $display("FAIL arst_valid0: got %b want 0", qif.q_o_valid0); end checks++;
        @(negedge q_clk);
        #1;
        q_rst = 1'b1;
        idle_inputs();
        #1;
        if (qif.q_o_count !== 4'd0) begin errors++; $display("FAIL arst_lost: got %0d want 0", qif.q_o_count); end checks++;
        if (qif.q_o_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", qif.q_o_empty); end checks++;
    endtask

`ifdef IQ_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        cycle(2'd2, 32'h7000_0000, 32'h7000_0001, 2'd0);
        cycle(2'd2, 32'h7000_0002, 32'h7000_0003, 2'd0);
        cycle(2'd1, 32'h7000_0004, 32'h0, 2'd0);
        if (qif.q_o_count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d want 5", qif.q_o_count); end checks++;
        @(posedge q_clk);
        qif.q_i_flush  = 1'b1;
        qif.q_i_wr_num = 2'd2;
        qif.q_i_instr0 = 32'h7000_00AA;
        qif.q_i_instr1 = 32'h7000_00BB;
        @(negedge q_clk);
        #1;
        idle_inputs();
        if (qif.q_o_count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", qif.q_o_count); end checks++;
        if (qif.q_o_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", qif.q_o_empty); end checks++;
        if (qif.q_o_valid0 !== 1'b0) begin errors++; $display("FAIL flush_valid0: got %b want 0", qif.q_o_valid0); end checks++;
        if (qif.q_o_drop !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", qif.q_o_drop); end checks++;
        cycle(2'd1, 32'h7000_0077, 32'h0, 2'd0);
        if (qif.q_o_instr0 !== 32'h7000_0077) begin errors++; $display("FAIL flush_repush: got %h want 70000077", qif.q_o_instr0); end checks++;
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_push_basic();
        test_fill_full();
        test_wrap();
        test_full_pushpop();
        test_underflow();
        test_async_reset();
`ifdef IQ_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
